// File: rtl/pan_pkg.sv
// Shared types and constants for the pan offset controller.
// Smooth panning is enabled by defining PAN_SMOOTH_EN.
package pan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    MOVING  = 2'd2
  } pan_state_t;

  // Offset widths driven to the shift stage.
  localparam int H_OFF_W = 11;
  localparam int V_OFF_W = 10;

  // Target arithmetic width; wide enough for limit + max delta and min delta.
  localparam int CALC_W = 13;

  // Default legal windows (frame size minus 512-pixel viewport).
  localparam int H_LIMIT_DEF = 768;
  localparam int V_LIMIT_DEF = 208;
  localparam int STEP_DEF    = 4;

endpackage

// File: rtl/pan_axis_stepper.sv
// One axis of the pan controller: holds the clamped target and the
// displayed offset, and advances the offset on frame boundaries.
// With PAN_SMOOTH_EN defined the offset ramps by at most STEP per advance;
// otherwise it jumps straight to the target.
module pan_axis_stepper
  import pan_pkg::*;
#(
  parameter int W     = 11,
  parameter int LIMIT = 768,
  parameter int STEP  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     load_i,
  input  logic                     abs_i,
  input  logic signed [CALC_W-1:0] delta_i,
  input  logic                     advance_i,
  output logic [W-1:0]             offset_o,
  output logic                     at_target_o
);

  localparam logic signed [CALC_W-1:0] LIM_S = CALC_W'(LIMIT);

  // A non-positive step would never reach the target.
  if (STEP < 1) begin : g_step_chk
    $error("pan_axis_stepper: STEP must be at least 1");
  end

  logic [W-1:0]             tgt_q, tgt_d;
  logic [W-1:0]             off_q, off_d;
  logic signed [CALC_W-1:0] base;
  logic signed [CALC_W-1:0] sum;

  // Saturate a signed request into the legal window [0, LIMIT].
  function automatic logic [W-1:0] clamp(input logic signed [CALC_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > LIM_S)
      return W'(LIMIT);
    else
      return v[W-1:0];
  endfunction

  // New target: absolute value or current target plus delta, then clamped.
  always_comb begin
    base  = abs_i ? '0 : {{(CALC_W-W){1'b0}}, tgt_q};
    sum   = base + delta_i;
    tgt_d = load_i ? clamp(sum) : tgt_q;
  end

`ifdef PAN_SMOOTH_EN
  localparam logic signed [CALC_W-1:0] STEP_S = CALC_W'(STEP);

  logic signed [CALC_W-1:0] tgt_s;
  logic signed [CALC_W-1:0] off_s;
  logic signed [CALC_W-1:0] diff;
  logic [W-1:0]             step_nxt;

  // Move toward the target by at most STEP; land exactly when close enough.
  always_comb begin
    tgt_s = {{(CALC_W-W){1'b0}}, tgt_q};
    off_s = {{(CALC_W-W){1'b0}}, off_q};
    diff  = tgt_s - off_s;
    if (diff > STEP_S)
      step_nxt = off_q + W'(STEP);
    else if (diff < -STEP_S)
      step_nxt = off_q - W'(STEP);
    else
      step_nxt = tgt_q;
    off_d       = advance_i ? step_nxt : off_q;
    at_target_o = (step_nxt == tgt_q);
  end
`else
  // Jump straight to the target; an advance always lands.
  always_comb begin
    off_d       = advance_i ? tgt_q : off_q;
    at_target_o = 1'b1;
  end
`endif

  // Target and offset registers; reset clears both so the display starts at 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tgt_q <= '0;
      off_q <= '0;
    end else begin
      tgt_q <= tgt_d;
      off_q <= off_d;
    end
  end

  assign offset_o = off_q;

endmodule

// File: rtl/pan_offset_controller.sv
// Pan offset controller: accepts relative/absolute pan commands over a
// valid/ready handshake and commits clamped h/v offsets only on frame
// boundaries (new_frame_in), so a displayed frame never tears.
// Define PAN_SMOOTH_EN to ramp offsets by at most STEP per frame per axis.
module pan_offset_controller
  import pan_pkg::*;
#(
  parameter int H_LIMIT = H_LIMIT_DEF,
  parameter int V_LIMIT = V_LIMIT_DEF,
  parameter int STEP    = STEP_DEF
) (
  input  logic                clk_pixel_in,
  input  logic                rst_n_in,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic                cmd_abs_in,
  input  logic signed [11:0]  cmd_dx_in,
  input  logic signed [10:0]  cmd_dy_in,
  input  logic                new_frame_in,
  output logic [H_OFF_W-1:0]  h_offset_out,
  output logic [V_OFF_W-1:0]  v_offset_out,
  output logic                busy_out
);

  pan_state_t state_q;
  logic       ready_q;
  logic       busy_q;

  logic                     accept;
  logic                     advance;
  logic                     h_at, v_at;
  logic                     done;
  logic signed [CALC_W-1:0] dx_ext;
  logic signed [CALC_W-1:0] dy_ext;

  // ready_q is only ever high in IDLE, so it alone qualifies the transfer.
  assign accept  = cmd_valid_in && ready_q;
  // Frame pulses in IDLE must not touch the offsets.
  assign advance = new_frame_in && (state_q != IDLE);
  assign done    = h_at && v_at;

  assign dx_ext = {cmd_dx_in[11], cmd_dx_in};
  assign dy_ext = {{2{cmd_dy_in[10]}}, cmd_dy_in};

  pan_axis_stepper #(
    .W     (H_OFF_W),
    .LIMIT (H_LIMIT),
    .STEP  (STEP)
  ) u_h_axis (
    .clk_i       (clk_pixel_in),
    .rst_n_i     (rst_n_in),
    .load_i      (accept),
    .abs_i       (cmd_abs_in),
    .delta_i     (dx_ext),
    .advance_i   (advance),
    .offset_o    (h_offset_out),
    .at_target_o (h_at)
  );

  pan_axis_stepper #(
    .W     (V_OFF_W),
    .LIMIT (V_LIMIT),
    .STEP  (STEP)
  ) u_v_axis (
    .clk_i       (clk_pixel_in),
    .rst_n_i     (rst_n_in),
    .load_i      (accept),
    .abs_i       (cmd_abs_in),
    .delta_i     (dy_ext),
    .advance_i   (advance),
    .offset_o    (v_offset_out),
    .at_target_o (v_at)
  );

  // Control FSM with registered ready/busy outputs.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= PENDING;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        PENDING: begin
          if (new_frame_in) begin
            if (done) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
`ifdef PAN_SMOOTH_EN
              state_q <= MOVING;
`else
              state_q <= PENDING;
`endif
            end
          end
        end
`ifdef PAN_SMOOTH_EN
        MOVING: begin
          if (new_frame_in && done) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_out = ready_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_pan_offset_controller.sv
// Directed testbench for pan_offset_controller. Runs the jump-mode scenarios
// in the default build and the ramp scenario when PAN_SMOOTH_EN is defined.
module tb_pan_offset_controller;

  logic               clk;
  logic               rst_n;
  logic               valid;
  logic               ready;
  logic               abs_cmd;
  logic signed [11:0] dx;
  logic signed [10:0] dy;
  logic               nf;
  logic [10:0]        h_off;
  logic [9:0]         v_off;
  logic               busy;

  int checks = 0;
  int errors = 0;

  pan_offset_controller #(
    .H_LIMIT (768),
    .V_LIMIT (208),
    .STEP    (4)
  ) dut (
    .clk_pixel_in  (clk),
    .rst_n_in      (rst_n),
    .cmd_valid_in  (valid),
    .cmd_ready_out (ready),
    .cmd_abs_in    (abs_cmd),
    .cmd_dx_in     (dx),
    .cmd_dy_in     (dy),
    .new_frame_in  (nf),
    .h_offset_out  (h_off),
    .v_offset_out  (v_off),
    .busy_out      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for a single edge, then drop valid.
  task automatic send_cmd(input logic a, input int x, input int y, input logic with_frame);
    @(negedge clk);
    valid   = 1'b1;
    abs_cmd = a;
    dx      = 12'(x);
    dy      = 11'(y);
    nf      = with_frame;
    @(posedge clk);
    #1;
    valid = 1'b0;
    nf    = 1'b0;
  endtask

  // One-cycle frame pulse.
  task automatic frame_pulse();
    @(negedge clk);
    nf = 1'b1;
    @(posedge clk);
    #1;
    nf = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({h_off, v_off} !== {11'd0, 10'd0}) begin errors++; $display("FAIL reset_offsets got h=%0d v=%0d want h=0 v=0", h_off, v_off); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", ready); end
    @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", ready); end
  endtask

  task automatic test_relative();
    send_cmd(1'b0, 100, 50, 1'b0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rel_ready_after_accept got %b want 0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rel_busy_after_accept got %b want 1", busy); end
    @(posedge clk);
    #1;
    checks++; if ({h_off, v_off} !== {11'd0, 10'd0}) begin errors++; $display("FAIL rel_no_early_change got h=%0d v=%0d want h=0 v=0", h_off, v_off); end
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd100, 10'd50}) begin errors++; $display("FAIL rel_offsets got h=%0d v=%0d want h=100 v=50", h_off, v_off); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy_done got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rel_ready_back got %b want 1", ready); end
  endtask

  task automatic test_clamp();
    // Frame directly after acceptance exercises the two-cycle minimum latency.
    send_cmd(1'b0, 1000, 0, 1'b0);
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd768, 10'd50}) begin errors++; $display("FAIL clamp_h_high got h=%0d v=%0d want h=768 v=50", h_off, v_off); end
    send_cmd(1'b0, -2000, 0, 1'b0);
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd0, 10'd50}) begin errors++; $display("FAIL clamp_h_low got h=%0d v=%0d want h=0 v=50", h_off, v_off); end
    send_cmd(1'b1, 50, 300, 1'b0);
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd50, 10'd208}) begin errors++; $display("FAIL clamp_v_abs got h=%0d v=%0d want h=50 v=208", h_off, v_off); end
    send_cmd(1'b1, -5, 20, 1'b0);
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd0, 10'd20}) begin errors++; $display("FAIL clamp_h_abs_neg got h=%0d v=%0d want h=0 v=20", h_off, v_off); end
  endtask

  task automatic test_simultaneous();
    send_cmd(1'b0, 8, 8, 1'b1);
    checks++; if ({h_off, v_off} !== {11'd0, 10'd20}) begin errors++; $display("FAIL simul_unchanged got h=%0d v=%0d want h=0 v=20", h_off, v_off); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_busy got %b want 1", busy); end
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd8, 10'd28}) begin errors++; $display("FAIL simul_applied got h=%0d v=%0d want h=8 v=28", h_off, v_off); end
  endtask

  task automatic test_idle_frame();
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd8, 10'd28}) begin errors++; $display("FAIL idle_frame got h=%0d v=%0d want h=8 v=28", h_off, v_off); end
  endtask

  task automatic test_ignore_pending();
    send_cmd(1'b1, 300, 100, 1'b0);
    // A second command while pending must neither be accepted nor alter the target.
    send_cmd(1'b1, 5, 5, 1'b0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pending_ready got %b want 0", ready); end
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd300, 10'd100}) begin errors++; $display("FAIL pending_ignored got h=%0d v=%0d want h=300 v=100", h_off, v_off); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pending_busy_done got %b want 0", busy); end
  endtask

  task automatic test_same_target();
    send_cmd(1'b1, 300, 100, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy got %b want 1", busy); end
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd300, 10'd100}) begin errors++; $display("FAIL same_offsets got h=%0d v=%0d want h=300 v=100", h_off, v_off); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy_done got %b want 0", busy); end
  endtask

  task automatic test_smooth();
    send_cmd(1'b1, 10, 3, 1'b0);
    @(negedge clk);
    valid   = 1'b1;
    abs_cmd = 1'b1;
    dx      = 12'sd100;
    dy      = 11'sd100;
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd4, 10'd3}) begin errors++; $display("FAIL smooth_f1 got h=%0d v=%0d want h=4 v=3", h_off, v_off); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL smooth_busy_f1 got %b want 1", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL smooth_ready_f1 got %b want 0", ready); end
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd8, 10'd3}) begin errors++; $display("FAIL smooth_f2 got h=%0d v=%0d want h=8 v=3", h_off, v_off); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL smooth_busy_f2 got %b want 1", busy); end
    frame_pulse();
    valid = 1'b0;
    checks++; if ({h_off, v_off} !== {11'd10, 10'd3}) begin errors++; $display("FAIL smooth_f3 got h=%0d v=%0d want h=10 v=3", h_off, v_off); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL smooth_busy_f3 got %b want 0", busy); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL smooth_no_accept got busy %b want 0", busy); end
  endtask

  task automatic test_reset_pending();
    send_cmd(1'b1, 200, 100, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstp_busy_before got %b want 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({h_off, v_off} !== {11'd0, 10'd0}) begin errors++; $display("FAIL rstp_offsets got h=%0d v=%0d want h=0 v=0", h_off, v_off); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstp_busy got %b want 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstp_ready got %b want 0", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_pulse();
    frame_pulse();
    checks++; if ({h_off, v_off} !== {11'd0, 10'd0}) begin errors++; $display("FAIL rstp_discarded got h=%0d v=%0d want h=0 v=0", h_off, v_off); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstp_busy_after got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstp_ready_after got %b want 1", ready); end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b0;
    abs_cmd = 1'b0;
    dx      = '0;
    dy      = '0;
    nf      = 1'b0;
    test_reset();
`ifdef PAN_SMOOTH_EN
    test_smooth();
`else
    test_relative();
    test_clamp();
    test_simultaneous();
    test_idle_frame();
    test_ignore_pending();
    test_same_target();
`endif
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
